// File: rtl/pipelined_csel_adder_pkg.sv
// Shared constants and helpers for the pipelined carry-select adder.
//   OP_ADD / OP_SUB : encodings of the 'sub' operand-conditioning bit
//   chunk_w()       : slice width for a given operand width and stage count
package adder_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Guarded so an illegal STAGES value still elaborates far enough
    // to reach the parameter check in the top level.
    function automatic int chunk_w(input int width, input int stages);
        return (stages > 0) ? width / stages : width;
    endfunction

endpackage

// File: rtl/pipelined_csel_adder_if.sv
// Operand/result handshake bundle for pipelined_csel_adder.
//   in_valid/in_ready   : operand transfer (a, b, cin, sub)
//   out_valid/out_ready : result transfer (sum, cout, ovf)
//   master : the producer/consumer side (testbench or surrounding datapath)
//   slave  : the adder itself
interface pipelined_csel_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipelined_csel_adder_slice.sv
// One carry-select slice (combinational).
//   a, b     : CHUNK-bit operand slices (b already conditioned for subtract)
//   c_in     : carry from the previous slice (registered upstream)
//   s        : CHUNK-bit slice sum
//   c_out    : carry out of the slice MSB
//   c_msb_in : carry into the slice MSB, used for signed overflow on the top slice
module csel_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             c_in,
    output logic [CHUNK-1:0] s,
    output logic             c_out,
    output logic             c_msb_in
);
    logic [CHUNK:0] sum_c0;
    logic [CHUNK:0] sum_c1;

    // Both carry-in hypotheses are evaluated up front so only the mux
    // sits behind the registered incoming carry.
    assign sum_c0 = {1'b0, a} + {1'b0, b};
    assign sum_c1 = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, 1'b1};

    assign {c_out, s} = c_in ? sum_c1 : sum_c0;

    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out directly.
    assign c_msb_in = a[CHUNK-1] ^ b[CHUNK-1] ^ s[CHUNK-1];
endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready on both sides.
// Operands are cut into STAGES slices of WIDTH/STAGES bits; stage k resolves
// slice k using the carry registered by stage k-1. Throughput 1 op/cycle,
// latency STAGES cycles, full backpressure.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : pipelined_csel_adder_if slave (in_*, a, b, cin, sub, out_*, sum, cout, ovf)
module pipelined_csel_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    pipelined_csel_adder_if.slave  bus
);
    localparam int               CHUNK      = chunk_w(WIDTH, STAGES);
    localparam int               LAST       = STAGES - 1;
    localparam logic [WIDTH-1:0] SLICE_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

    if ((STAGES < 1) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
        $error("pipelined_csel_adder: WIDTH (%0d) must be a multiple of STAGES (%0d >= 1)",
               WIDTH, STAGES);
    end

    // Stage registers: valid, partially resolved result, slice carry,
    // carry into the slice MSB, and the operands still to be consumed.
    logic             vld_p [STAGES];
    logic [WIDTH-1:0] res_p [STAGES];
    logic             cy_p  [STAGES];
    logic             cm_p  [STAGES];
    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];

    // Per-stage inputs and slice results.
    logic             vin    [STAGES];
    logic [WIDTH-1:0] a_in   [STAGES];
    logic [WIDTH-1:0] b_in   [STAGES];
    logic             c_in   [STAGES];
    logic [WIDTH-1:0] res_nx [STAGES];
    logic [CHUNK-1:0] s_w    [STAGES];
    logic             co_w   [STAGES];
    logic             cm_w   [STAGES];
    logic             rdy    [STAGES+1];

    // A stage can load when it is empty or its content moves on this edge.
    always_comb begin
        rdy[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !vld_p[k] || rdy[k+1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] base;

        if (k == 0) begin : g_head
            // Subtraction folds into the add: a + ~b + ~cin.
            assign vin[k]  = bus.in_valid;
            assign a_in[k] = bus.a;
            assign b_in[k] = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
            assign c_in[k] = bus.cin ^ bus.sub;
            assign base    = '0;
        end else begin : g_body
            assign vin[k]  = vld_p[k-1];
            assign a_in[k] = a_p[k-1];
            assign b_in[k] = b_p[k-1];
            assign c_in[k] = cy_p[k-1];
            assign base    = res_p[k-1];
        end

        csel_slice #(.CHUNK(CHUNK)) u_slice (
            .a        (a_in[k][k*CHUNK +: CHUNK]),
            .b        (b_in[k][k*CHUNK +: CHUNK]),
            .c_in     (c_in[k]),
            .s        (s_w[k]),
            .c_out    (co_w[k]),
            .c_msb_in (cm_w[k])
        );

        // Splice this slice's sum into the bits resolved so far.
        assign res_nx[k] = (base & ~(SLICE_MASK << (k * CHUNK)))
                         | ({{(WIDTH-CHUNK){1'b0}}, s_w[k]} << (k * CHUNK));
    end

    // ---- stage boundary: stage k captures slice k result ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_p[k] <= 1'b0;
                res_p[k] <= '0;
                cy_p[k]  <= 1'b0;
                cm_p[k]  <= 1'b0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld_p[k] <= vin[k];
                    // Data only moves with a real op so a bubble never
                    // disturbs the result held downstream.
                    if (vin[k]) begin
                        res_p[k] <= res_nx[k];
                        cy_p[k]  <= co_w[k];
                        cm_p[k]  <= cm_w[k];
                        a_p[k]   <= a_in[k];
                        b_p[k]   <= b_in[k];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld_p[LAST];
    assign bus.sum       = res_p[LAST];
    assign bus.cout      = cy_p[LAST];
    assign bus.ovf       = cm_p[LAST] ^ cy_p[LAST];
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Scoreboard bench for pipelined_csel_adder: three instances
// (8-bit/2 stages, 32-bit/4 stages, 8-bit/1 stage) share one clock.
module tb_pipelined_csel_adder;
    import adder_pkg::*;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipelined_csel_adder_if #(.WIDTH(8))  if0 ();
    pipelined_csel_adder_if #(.WIDTH(32)) if1 ();
    pipelined_csel_adder_if #(.WIDTH(8))  if2 ();

    pipelined_csel_adder #(.WIDTH(8),  .STAGES(2)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    pipelined_csel_adder #(.WIDTH(32), .STAGES(4)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
    pipelined_csel_adder #(.WIDTH(8),  .STAGES(1)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    exp_t sbq0[$];
    exp_t sbq1[$];
    exp_t sbq2[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   stall_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        return e;
    endfunction

    // Behavioural a+b model at width w.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic sub);
        logic [63:0] mask, aa, bb, full, low;
        exp_t e;
        mask = (64'd1 << w) - 64'd1;
        aa   = {32'd0, a} & mask;
        bb   = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
        full = aa + bb + 64'(cin ^ sub);
        low  = (aa & (mask >> 1)) + (bb & (mask >> 1)) + 64'(cin ^ sub);
        e.sum  = 32'(full & mask);
        e.cout = full[w];
        e.ovf  = low[w-1] ^ full[w];
        return e;
    endfunction

    function automatic logic lane_ready(input int lane);
        case (lane)
            0:       return if0.in_ready;
            1:       return if1.in_ready;
            default: return if2.in_ready;
        endcase
    endfunction

    function automatic logic lane_out_valid(input int lane);
        case (lane)
            0:       return if0.out_valid;
            1:       return if1.out_valid;
            default: return if2.out_valid;
        endcase
    endfunction

    task automatic idle(input int lane);
        case (lane)
            0:       if0.in_valid = 1'b0;
            1:       if1.in_valid = 1'b0;
            default: if2.in_valid = 1'b0;
        endcase
    endtask

    // Present an op and hold it until accepted; push the expectation on the accepting edge.
    task automatic send(input int lane, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic sub, input exp_t e);
        bit acc  = 0;
        bit done = 0;
        int waits = 0;
        case (lane)
            0: begin if0.in_valid = 1'b1; if0.a = a[7:0]; if0.b = b[7:0]; if0.cin = cin; if0.sub = sub; end
            1: begin if1.in_valid = 1'b1; if1.a = a;      if1.b = b;      if1.cin = cin; if1.sub = sub; end
            default: begin if2.in_valid = 1'b1; if2.a = a[7:0]; if2.b = b[7:0]; if2.cin = cin; if2.sub = sub; end
        endcase
        while (!done) begin
            @(negedge clk);
            if (lane_ready(lane)) acc = 1;
            else stall_cnt++;
            @(posedge clk);
            if (acc) begin
                case (lane)
                    0:       sbq0.push_back(e);
                    1:       sbq1.push_back(e);
                    default: sbq2.push_back(e);
                endcase
                done = 1;
            end
            #1;
            waits++;
            if (!done && waits > 50) begin
                total_cnt++;
                $display("FAIL send_timeout lane %0d: in_ready 0 required 1", lane);
                done = 1;
            end
        end
    endtask

    // Single op into an empty pipe: out_valid must rise exactly STAGES cycles after acceptance.
    task automatic lat_test(input int lane, input int stages, input logic [31:0] a,
                            input logic [31:0] b, input exp_t e);
        send(lane, a, b, 1'b0, OP_ADD, e);
        idle(lane);
        for (int c = 0; c < stages - 1; c++) begin
            check($sformatf("lane%0d latency_early%0d", lane, c), 32'(lane_out_valid(lane)), 32'd0);
            @(posedge clk); #1;
        end
        check($sformatf("lane%0d latency", lane), 32'(lane_out_valid(lane)), 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitors: pop and compare whenever a result is taken.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && if0.out_valid && if0.out_ready) begin
            if (sbq0.size() == 0) begin
                total_cnt++;
                $display("FAIL lane0 unexpected_result: got sum 0x%0h required no output", if0.sum);
            end else begin
                e = sbq0.pop_front();
                check("lane0 sum",  32'(if0.sum),  e.sum);
                check("lane0 cout", 32'(if0.cout), 32'(e.cout));
                check("lane0 ovf",  32'(if0.ovf),  32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && if1.out_valid && if1.out_ready) begin
            if (sbq1.size() == 0) begin
                total_cnt++;
                $display("FAIL lane1 unexpected_result: got sum 0x%0h required no output", if1.sum);
            end else begin
                e = sbq1.pop_front();
                check("lane1 sum",  if1.sum,       e.sum);
                check("lane1 cout", 32'(if1.cout), 32'(e.cout));
                check("lane1 ovf",  32'(if1.ovf),  32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && if2.out_valid && if2.out_ready) begin
            if (sbq2.size() == 0) begin
                total_cnt++;
                $display("FAIL lane2 unexpected_result: got sum 0x%0h required no output", if2.sum);
            end else begin
                e = sbq2.pop_front();
                check("lane2 sum",  32'(if2.sum),  e.sum);
                check("lane2 cout", 32'(if2.cout), 32'(e.cout));
                check("lane2 ovf",  32'(if2.ovf),  32'(e.ovf));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] sa [6] = '{8'h11, 8'h7F, 8'hF0, 8'h01, 8'hAA, 8'h3C};
    logic [7:0] sb [6] = '{8'h22, 8'h01, 8'h20, 8'hFF, 8'h55, 8'hC4};

    initial begin
        int wait_cyc;
        if0.in_valid = 0; if0.a = '0; if0.b = '0; if0.cin = 0; if0.sub = 0; if0.out_ready = 1;
        if1.in_valid = 0; if1.a = '0; if1.b = '0; if1.cin = 0; if1.sub = 0; if1.out_ready = 1;
        if2.in_valid = 0; if2.a = '0; if2.b = '0; if2.cin = 0; if2.sub = 0; if2.out_ready = 1;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Reset state
        check("rst out_valid", 32'(if0.out_valid), 32'd0);
        check("rst in_ready",  32'(if0.in_ready),  32'd1);
        check("rst sum",       32'(if0.sum),       32'd0);
        check("rst cout",      32'(if0.cout),      32'd0);
        check("rst ovf",       32'(if0.ovf),       32'd0);
        check("rst lane1 in_ready", 32'(if1.in_ready), 32'd1);
        check("rst lane2 out_valid", 32'(if2.out_valid), 32'd0);

        // 8-bit / 2 stages
        lat_test(0, 2, 32'd100, 32'd50, mk(32'd150, 1'b0, 1'b1));
        send(0, 32'd200,  32'd100,  1'b1, OP_ADD, mk(32'd45,   1'b1, 1'b0));
        send(0, 32'h0FF,  32'h001,  1'b0, OP_ADD, mk(32'h00,   1'b1, 1'b0));
        send(0, 32'h00F,  32'h001,  1'b0, OP_ADD, mk(32'h10,   1'b0, 1'b0));
        send(0, 32'd50,   32'd100,  1'b0, OP_SUB, mk(32'hCE,   1'b0, 1'b0));
        send(0, 32'h080,  32'h001,  1'b0, OP_SUB, mk(32'h7F,   1'b1, 1'b1));
        idle(0);
        repeat (4) @(posedge clk);
        #1;

        // Back-to-back stream
        stall_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            send(0, 32'(sa[i]), 32'(sb[i]), i[1], i[0], model(8, 32'(sa[i]), 32'(sb[i]), i[1], i[0]));
        end
        idle(0);
        check("stream in_ready_stalls", 32'(stall_cnt), 32'd0);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure
        if0.out_ready = 0;
        send(0, 32'h12, 32'h34, 1'b0, OP_ADD, mk(32'h46, 1'b0, 1'b0));
        send(0, 32'h90, 32'h90, 1'b0, OP_ADD, mk(32'h20, 1'b1, 1'b1));
        @(negedge clk);
        check("stall in_ready_full", 32'(if0.in_ready),  32'd0);
        check("stall out_valid",     32'(if0.out_valid), 32'd1);
        fork
            begin
                send(0, 32'h05, 32'h03, 1'b1, OP_SUB, mk(32'h01, 1'b1, 1'b0));
                idle(0);
            end
            begin
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    check($sformatf("stall sum_hold%0d", c), 32'(if0.sum), 32'h46);
                    check($sformatf("stall in_ready%0d", c), 32'(if0.in_ready), 32'd0);
                end
                @(posedge clk);
                #1 if0.out_ready = 1;
            end
        join
        repeat (4) @(posedge clk);
        #1;

        // Reset with ops in flight
        if0.out_ready = 0;
        send(0, 32'h21, 32'h11, 1'b0, OP_ADD, mk(32'h32, 1'b0, 1'b0));
        send(0, 32'h44, 32'h22, 1'b0, OP_ADD, mk(32'h66, 1'b0, 1'b0));
        idle(0);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        sbq0.delete();
        check("flush out_valid", 32'(if0.out_valid), 32'd0);
        check("flush in_ready",  32'(if0.in_ready),  32'd1);
        if0.out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        send(0, 32'h3C, 32'h0A, 1'b0, OP_SUB, mk(32'h32, 1'b1, 1'b0));
        idle(0);

        // 32-bit / 4 stages
        lat_test(1, 4, 32'h0000FFFF, 32'h00000001, mk(32'h00010000, 1'b0, 1'b0));
        send(1, 32'hFFFFFFFF, 32'h00000001, 1'b0, OP_ADD, mk(32'h00000000, 1'b1, 1'b0));
        send(1, 32'h7FFFFFFF, 32'h00000001, 1'b0, OP_ADD, mk(32'h80000000, 1'b0, 1'b1));
        send(1, 32'h00000000, 32'h00000001, 1'b0, OP_SUB, mk(32'hFFFFFFFF, 1'b0, 1'b0));
        send(1, 32'h12345678, 32'h0FEDCBA9, 1'b1, OP_ADD, mk(32'h22222222, 1'b0, 1'b0));
        send(1, 32'h89ABCDEF, 32'h76543210, 1'b0, OP_SUB,
             model(32, 32'h89ABCDEF, 32'h76543210, 1'b0, OP_SUB));
        idle(1);

        // 8-bit / 1 stage
        lat_test(2, 1, 32'd100, 32'd50, mk(32'd150, 1'b0, 1'b1));
        send(2, 32'd200,  32'd100,  1'b1, OP_ADD, mk(32'd45,   1'b1, 1'b0));
        send(2, 32'h0FF,  32'h001,  1'b0, OP_ADD, mk(32'h00,   1'b1, 1'b0));
        send(2, 32'd50,   32'd100,  1'b0, OP_SUB, mk(32'hCE,   1'b0, 1'b0));
        send(2, 32'h080,  32'h001,  1'b0, OP_SUB, mk(32'h7F,   1'b1, 1'b1));
        idle(2);

        wait_cyc = 0;
        while ((sbq0.size() + sbq1.size() + sbq2.size()) != 0 && wait_cyc < 100) begin
            @(posedge clk);
            wait_cyc++;
        end
        #1;
        check("drain pending", 32'(sbq0.size() + sbq1.size() + sbq2.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
